// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), each taking WIDTH cycles into HI/LO.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       Ctl,
    input  logic [SHW-1:0]   Shamt,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic [WIDTH-1:0] DataOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [1:0]       fsm_state
);
    // Handshake: Start is accepted on a rising edge with Start=1 and Busy=0;
    // every accepted request produces exactly one Done pulse (unless reset aborts it).
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    localparam logic [SHW:0] CNT_INIT = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

    localparam logic [2:0] CTL_AND   = 3'b000;
    localparam logic [2:0] CTL_OR    = 3'b001;
    localparam logic [2:0] CTL_ADD   = 3'b010;
    localparam logic [2:0] CTL_SRL   = 3'b011;
    localparam logic [2:0] CTL_MULTU = 3'b100;
    localparam logic [2:0] CTL_DIVU  = 3'b101;
    localparam logic [2:0] CTL_SUB   = 3'b110;
    localparam logic [2:0] CTL_SLT   = 3'b111;

    state_t             state_q, state_n;
    logic [SHW:0]       cnt_q, cnt_n;
    logic [WIDTH-1:0]   wk_hi_q, wk_hi_n;
    logic [WIDTH-1:0]   wk_lo_q, wk_lo_n;
    logic [WIDTH-1:0]   wk_b_q, wk_b_n;
    logic [WIDTH-1:0]   data_out_n, hi_n, lo_n;
    logic               done_n, div_zero_n;
    logic [WIDTH:0]     mul_sum, div_shl, div_diff;
    logic               div_ge;

    assign Busy      = (state_q != IDLE);
    assign fsm_state = state_q;

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        wk_hi_n    = wk_hi_q;
        wk_lo_n    = wk_lo_q;
        wk_b_n     = wk_b_q;
        data_out_n = DataOut;
        hi_n       = Hi;
        lo_n       = Lo;
        done_n     = 1'b0;
        div_zero_n = 1'b0;

        // Multiply: add multiplicand when the low multiplier bit is set, then shift {hi,lo} right.
        mul_sum  = {1'b0, wk_hi_q} + (wk_lo_q[0] ? {1'b0, wk_b_q} : '0);
        // Divide: the partial remainder stays below the divisor, so a borrow in the top bit means "does not fit".
        div_shl  = {wk_hi_q, wk_lo_q[WIDTH-1]};
        div_diff = div_shl - {1'b0, wk_b_q};
        div_ge   = ~div_diff[WIDTH];

        case (state_q)
            IDLE: begin
                if (Start) begin
                    done_n = 1'b1;
                    case (Ctl)
                        CTL_AND: data_out_n = DataA & DataB;
                        CTL_OR:  data_out_n = DataA | DataB;
                        CTL_ADD: data_out_n = DataA + DataB;
                        CTL_SUB: data_out_n = DataA - DataB;
                        CTL_SLT: data_out_n = {{(WIDTH-1){1'b0}}, $signed(DataA) < $signed(DataB)};
                        CTL_SRL: data_out_n = DataA >> Shamt;
                        CTL_MULTU: begin
                            done_n  = 1'b0;
                            state_n = MUL;
                            cnt_n   = CNT_INIT;
                            wk_hi_n = '0;
                            wk_lo_n = DataA;
                            wk_b_n  = DataB;
                        end
                        default: begin
                            if (DataB == '0) begin
                                div_zero_n = 1'b1;
                            end else begin
                                done_n  = 1'b0;
                                state_n = DIV;
                                cnt_n   = CNT_INIT;
                                wk_hi_n = '0;
                                wk_lo_n = DataA;
                                wk_b_n  = DataB;
                            end
                        end
                    endcase
                end
            end
            MUL: begin
                wk_hi_n = mul_sum[WIDTH:1];
                wk_lo_n = {mul_sum[0], wk_lo_q[WIDTH-1:1]};
                cnt_n   = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    hi_n       = wk_hi_n;
                    lo_n       = wk_lo_n;
                    data_out_n = wk_lo_n;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
            end
            DIV: begin
                wk_hi_n = div_ge ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0];
                wk_lo_n = {wk_lo_q[WIDTH-2:0], div_ge};
                cnt_n   = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    hi_n       = wk_hi_n;
                    lo_n       = wk_lo_n;
                    data_out_n = wk_lo_n;
                    done_n     = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wk_hi_q <= '0;
            wk_lo_q <= '0;
            wk_b_q  <= '0;
            DataOut <= '0;
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            wk_hi_q <= wk_hi_n;
            wk_lo_q <= wk_lo_n;
            wk_b_q  <= wk_b_n;
            DataOut <= data_out_n;
            Hi      <= hi_n;
            Lo      <= lo_n;
            Done    <= done_n;
            DivZero <= div_zero_n;
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: WIDTH=32 and WIDTH=8 instances, each checked every cycle
// against an arithmetic reference model, plus hand-computed literal expectations.
module tb_multicycle_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sel8 = 1'b0;
    logic [2:0]  ctl = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        start32, start8;

    logic [31:0] dout32, hi32, lo32;
    logic        busy32, done32, dz32;
    logic [1:0]  st32;
    logic [7:0]  dout8, hi8, lo8;
    logic        busy8, done8, dz8;
    logic [1:0]  st8;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int          left;
        bit          done;
        bit          dz;
        logic [31:0] dout;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] phi;
        logic [31:0] plo;
    } model_t;

    model_t m32, m8;

    always #5 clk = ~clk;

    assign start32 = start & ~sel8;
    assign start8  = start & sel8;

    multicycle_alu #(.WIDTH(32), .SHW(5)) dut32 (
        .clk(clk), .rst(rst_n), .Start(start32), .Ctl(ctl), .Shamt(shamt),
        .DataA(a), .DataB(b), .DataOut(dout32), .Hi(hi32), .Lo(lo32),
        .Busy(busy32), .Done(done32), .DivZero(dz32), .fsm_state(st32)
    );

    multicycle_alu #(.WIDTH(8), .SHW(3)) dut8 (
        .clk(clk), .rst(rst_n), .Start(start8), .Ctl(ctl), .Shamt(shamt[2:0]),
        .DataA(a[7:0]), .DataB(b[7:0]), .DataOut(dout8), .Hi(hi8), .Lo(lo8),
        .Busy(busy8), .Done(done8), .DivZero(dz8), .fsm_state(st8)
    );

    // Reference model: results computed with plain arithmetic at acceptance, then
    // released after w cycles for MULTU/DIVU.
    function automatic model_t model_step(model_t m, bit st, logic [2:0] c, logic [4:0] sh,
                                          logic [31:0] a_in, logic [31:0] b_in, int w);
        model_t      n = m;
        logic [63:0] mask, x, y, p;
        longint      sx, sy;
        int          s;
        mask = (64'd1 << w) - 64'd1;
        x = {32'd0, a_in} & mask;
        y = {32'd0, b_in} & mask;
        n.done = 1'b0;
        n.dz = 1'b0;
        if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.hi = m.phi;
                n.lo = m.plo;
                n.dout = m.plo;
                n.done = 1'b1;
            end
        end else if (st) begin
            n.done = 1'b1;
            case (c)
                3'b000: n.dout = 32'(x & y);
                3'b001: n.dout = 32'(x | y);
                3'b010: n.dout = 32'((x + y) & mask);
                3'b110: n.dout = 32'((x - y) & mask);
                3'b111: begin
                    sx = longint'(x) - (x[w-1] ? longint'(mask) + 64'sd1 : 64'sd0);
                    sy = longint'(y) - (y[w-1] ? longint'(mask) + 64'sd1 : 64'sd0);
                    n.dout = (sx < sy) ? 32'd1 : 32'd0;
                end
                3'b011: begin
                    s = int'(sh) % w;
                    n.dout = 32'(x >> s);
                end
                3'b100: begin
                    p = x * y;
                    n.phi = 32'((p >> w) & mask);
                    n.plo = 32'(p & mask);
                    n.left = w;
                    n.done = 1'b0;
                end
                default: begin
                    if (y == 64'd0) begin
                        n.dz = 1'b1;
                    end else begin
                        n.plo = 32'(x / y);
                        n.phi = 32'(x % y);
                        n.left = w;
                        n.done = 1'b0;
                    end
                end
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32 <= '{default: 0};
            m8  <= '{default: 0};
        end else begin
            m32 <= model_step(m32, start32, ctl, shamt, a, b, 32);
            m8  <= model_step(m8, start8, ctl, shamt, a, b, 8);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare: {busy, done, divzero, dataout, hi, lo} against the model.
    always @(negedge clk) begin
        check("cycle32", {29'd0, busy32, done32, dz32, dout32, hi32, lo32},
              {29'd0, m32.left > 0, m32.done, m32.dz, m32.dout, m32.hi, m32.lo});
        check("cycle8", {29'd0, busy8, done8, dz8, 24'd0, dout8, 24'd0, hi8, 24'd0, lo8},
              {29'd0, m8.left > 0, m8.done, m8.dz, m8.dout, m8.hi, m8.lo});
    end

    function automatic bit cur_done();
        return sel8 ? done8 : done32;
    endfunction

    function automatic bit cur_busy();
        return sel8 ? busy8 : busy32;
    endfunction

    // Issue one request and wait (bounded) for its Done pulse; returns at the
    // negedge where Done is visible. With noise set, random Start pulses hit the busy DUT.
    task automatic do_op(input bit use8, input logic [2:0] c, input logic [4:0] sh,
                         input logic [31:0] av, input logic [31:0] bv, input bit noise,
                         output int busy_cycles);
        @(negedge clk);
        sel8 = use8; start = 1'b1; ctl = c; shamt = sh; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (cur_done()) break;
            if (cur_busy()) busy_cycles++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                ctl = 3'($urandom_range(0, 7));
                a = $urandom;
                b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk32("done_seen", 32'(cur_done()), 32'd1);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        bit saw_done;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk32("reset_dout", dout32, 32'd0);
        chk32("reset_hilo", hi32 | lo32, 32'd0);
        chk32("reset_flags", {29'd0, busy32, done32, dz32}, 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 3'b010, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, bc);
        chk32("add_result", dout32, 32'h8000_0000);
        chk32("add_busy", 32'(bc), 32'd0);
        @(negedge clk);
        chk32("add_done_once", 32'(done32), 32'd0);

        do_op(1'b0, 3'b110, 5'd0, 32'd0, 32'd1, 1'b0, bc);
        chk32("sub_result", dout32, 32'hFFFF_FFFF);
        do_op(1'b0, 3'b111, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, bc);
        chk32("slt_result", dout32, 32'd1);
        do_op(1'b0, 3'b011, 5'd31, 32'h8000_0000, 32'd0, 1'b0, bc);
        chk32("srl_result", dout32, 32'd1);

        do_op(1'b0, 3'b100, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, bc);
        chk32("mul_busy_cycles", 32'(bc), 32'd32);
        chk32("mul_hi", hi32, 32'hFFFF_FFFE);
        chk32("mul_lo", lo32, 32'h0000_0001);
        chk32("mul_dout", dout32, 32'h0000_0001);
        @(negedge clk);
        chk32("mul_done_once", 32'(done32), 32'd0);

        do_op(1'b0, 3'b101, 5'd0, 32'd100, 32'd7, 1'b0, bc);
        chk32("div_lo", lo32, 32'd14);
        chk32("div_hi", hi32, 32'd2);
        chk32("div_dz", 32'(dz32), 32'd0);
        do_op(1'b0, 3'b101, 5'd0, 32'd5, 32'd0, 1'b0, bc);
        chk32("divz_busy", 32'(bc), 32'd0);
        chk32("divz_flag", 32'(dz32), 32'd1);
        chk32("divz_hi", hi32, 32'd2);
        chk32("divz_lo", lo32, 32'd14);
        chk32("divz_dout", dout32, 32'd14);

        // Abort a MULTU with an asynchronous reset mid-cycle.
        @(negedge clk);
        start = 1'b1; ctl = 3'b100; a = 32'd12345; b = 32'd678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk32("async_rst_dout", dout32, 32'd0);
        chk32("async_rst_hilo", hi32 | lo32, 32'd0);
        chk32("async_rst_flags", {29'd0, busy32, done32, dz32}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done32) saw_done = 1'b1;
        end
        chk32("no_done_after_abort", 32'(saw_done), 32'd0);
        do_op(1'b0, 3'b010, 5'd0, 32'd3, 32'd4, 1'b0, bc);
        chk32("add_after_reset", dout32, 32'd7);

        // Back-to-back: ADD issued in the MULTU Done cycle.
        do_op(1'b0, 3'b100, 5'd0, 32'd3, 32'd5, 1'b0, bc);
        chk32("b2b_mul_lo", lo32, 32'd15);
        start = 1'b1; ctl = 3'b010; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        chk32("b2b_add_dout", dout32, 32'd2);
        chk32("b2b_add_done", 32'(done32), 32'd1);

        do_op(1'b1, 3'b100, 5'd0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, bc);
        chk32("w8_busy_cycles", 32'(bc), 32'd8);
        chk32("w8_hi", {24'd0, hi8}, 32'h0000_00FE);
        chk32("w8_lo", {24'd0, lo8}, 32'h0000_0001);

        // Random traffic, including Start while busy and back-to-back requests.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i % 500 == 0) sel8 = ~sel8;
            start = ($urandom_range(0, 2) == 0);
            ctl = 3'($urandom_range(0, 7));
            shamt = 5'($urandom_range(0, 31));
            a = rnd_op();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_op();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
